// File: rtl/fp_execute_pipe_if.sv
// Issue, datapath and retire signals of the FP execute stage.
// master = issue/datapath/writeback side, slave = the execute stage itself.
interface fp_execute_pipe_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) ();
   logic             in_valid;
   logic             in_ready;
   logic [TAG_W-1:0] in_tag;
   logic [XLEN-1:0]  in_fp_rs1;
   logic [XLEN-1:0]  in_fp_rs2;
   logic [XLEN-1:0]  in_fp_rs3;
   logic [XLEN-1:0]  in_int_rs1;
   logic [4:0]       in_ctrl;
   logic [2:0]       in_rm;
   logic             in_int_to_fp;
   logic             in_iter;

   logic             dp_valid;
   logic             dp_start;
   logic             dp_kill;
   logic [XLEN-1:0]  dp_a;
   logic [XLEN-1:0]  dp_b;
   logic [XLEN-1:0]  dp_c;
   logic [4:0]       dp_ctrl;
   logic [2:0]       dp_rm;
   logic [XLEN-1:0]  dp_pipe_result;
   logic [4:0]       dp_pipe_fflags;
   logic             dp_iter_done;
   logic [XLEN-1:0]  dp_iter_result;
   logic [4:0]       dp_iter_fflags;

   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [4:0]       out_fflags;
   logic [TAG_W-1:0] out_tag;

   logic             flush;
   logic             fflags_clr;
   logic [4:0]       fflags_acc;
   logic             busy;

   modport master (
      output in_valid, in_tag, in_fp_rs1, in_fp_rs2, in_fp_rs3, in_int_rs1,
             in_ctrl, in_rm, in_int_to_fp, in_iter,
             dp_pipe_result, dp_pipe_fflags, dp_iter_done, dp_iter_result, dp_iter_fflags,
             out_ready, flush, fflags_clr,
      input  in_ready, dp_valid, dp_start, dp_kill, dp_a, dp_b, dp_c, dp_ctrl, dp_rm,
             out_valid, out_result, out_fflags, out_tag, fflags_acc, busy
   );

   modport slave (
      input  in_valid, in_tag, in_fp_rs1, in_fp_rs2, in_fp_rs3, in_int_rs1,
             in_ctrl, in_rm, in_int_to_fp, in_iter,
             dp_pipe_result, dp_pipe_fflags, dp_iter_done, dp_iter_result, dp_iter_fflags,
             out_ready, flush, fflags_clr,
      output in_ready, dp_valid, dp_start, dp_kill, dp_a, dp_b, dp_c, dp_ctrl, dp_rm,
             out_valid, out_result, out_fflags, out_tag, fflags_acc, busy
   );
endinterface

// File: rtl/fp_execute_pipe.sv
// Handshaked FP execute stage: registered operand issue, pipelined and iterative
// classes, in-order retire FIFO with credit-based admission and sticky fflags.
module fp_execute_pipe #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned TAG_W     = 5,
   parameter int unsigned PIPE_LAT  = 3,
   parameter int unsigned OUT_DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   fp_execute_pipe_if.slave io
);

   localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OCC_W = $clog2(OUT_DEPTH + PIPE_LAT + 2) + 1;

   typedef enum logic {ST_IDLE, ST_ITER} state_t;

   state_t state_q, state_d;

   logic [PIPE_LAT:0]            pv_q, pv_d;
   logic [PIPE_LAT:0][TAG_W-1:0] ptag_q;
   logic [TAG_W-1:0]             iter_tag_q;

   logic [XLEN-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d, dp_c_q, dp_c_d;
   logic [4:0]      dp_ctrl_q, dp_ctrl_d;
   logic [2:0]      dp_rm_q, dp_rm_d;
   logic            dp_start_q, dp_kill_q, kill_d;

   logic [XLEN-1:0]  res_mem [OUT_DEPTH];
   logic [4:0]       flg_mem [OUT_DEPTH];
   logic [TAG_W-1:0] tag_mem [OUT_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

   logic [4:0] acc_q, acc_d;

   logic             accept, pop, push, pipe_push, iter_push, pipe_empty, in_ready;
   logic [OCC_W-1:0] inflight, occ;
   logic [XLEN-1:0]  push_result;
   logic [4:0]       push_fflags;
   logic [TAG_W-1:0] push_tag;

   // Admission is credit based: FIFO entries plus everything still in flight.
   assign pipe_empty = ~|pv_q;
   assign pop        = (fifo_cnt_q != '0) && io.out_ready;
   assign inflight   = OCC_W'($countones(pv_q)) + OCC_W'(state_q == ST_ITER);
   assign occ        = OCC_W'(fifo_cnt_q) + inflight;
   assign in_ready   = !rst && !io.flush && (state_q == ST_IDLE)
                       && ((occ - OCC_W'(pop)) < OCC_W'(OUT_DEPTH))
                       && (!io.in_iter || pipe_empty);
   assign accept     = io.in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      iter_push = 1'b0;
      kill_d    = 1'b0;
      case (state_q)
         ST_IDLE: if (accept && io.in_iter) state_d = ST_ITER;
         ST_ITER: begin
            if (io.flush) begin
               state_d = ST_IDLE;
               kill_d  = 1'b1;
            end else if (io.dp_iter_done) begin
               state_d   = ST_IDLE;
               iter_push = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pv_d      = io.flush ? '0 : {pv_q[PIPE_LAT-1:0], accept && !io.in_iter};
   assign pipe_push = pv_q[PIPE_LAT] && !io.flush;
   assign push      = pipe_push || iter_push;

   // Pipelined and iterative completions are mutually exclusive by admission rule.
   always_comb begin
      push_result = io.dp_pipe_result;
      push_fflags = io.dp_pipe_fflags;
      push_tag    = ptag_q[PIPE_LAT];
      if (iter_push) begin
         push_result = io.dp_iter_result;
         push_fflags = io.dp_iter_fflags;
         push_tag    = iter_tag_q;
      end
   end

   // Operands are zero unless an op is being issued or an iterative op is active.
   always_comb begin
      dp_a_d    = '0;
      dp_b_d    = '0;
      dp_c_d    = '0;
      dp_ctrl_d = '0;
      dp_rm_d   = '0;
      if (accept) begin
         dp_a_d    = io.in_int_to_fp ? io.in_int_rs1 : io.in_fp_rs1;
         dp_b_d    = io.in_fp_rs2;
         dp_c_d    = io.in_fp_rs3;
         dp_ctrl_d = io.in_ctrl;
         dp_rm_d   = io.in_rm;
      end else if (state_d == ST_ITER) begin
         dp_a_d    = dp_a_q;
         dp_b_d    = dp_b_q;
         dp_c_d    = dp_c_q;
         dp_ctrl_d = dp_ctrl_q;
         dp_rm_d   = dp_rm_q;
      end
   end

   assign fifo_cnt_d = io.flush ? '0 : (fifo_cnt_q + CNT_W'(push) - CNT_W'(pop));

   always_comb begin
      acc_d = acc_q;
      if (pop) begin
         acc_d = io.fflags_clr ? flg_mem[rd_ptr_q] : (acc_q | flg_mem[rd_ptr_q]);
      end else if (io.fflags_clr) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pv_q       <= '0;
         dp_a_q     <= '0;
         dp_b_q     <= '0;
         dp_c_q     <= '0;
         dp_ctrl_q  <= '0;
         dp_rm_q    <= '0;
         dp_start_q <= 1'b0;
         dp_kill_q  <= 1'b0;
         iter_tag_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         acc_q      <= '0;
      end else begin
         state_q    <= state_d;
         pv_q       <= pv_d;
         dp_a_q     <= dp_a_d;
         dp_b_q     <= dp_b_d;
         dp_c_q     <= dp_c_d;
         dp_ctrl_q  <= dp_ctrl_d;
         dp_rm_q    <= dp_rm_d;
         dp_start_q <= accept && io.in_iter;
         dp_kill_q  <= kill_d;
         if (accept && io.in_iter) iter_tag_q <= io.in_tag;
         fifo_cnt_q <= fifo_cnt_d;
         acc_q      <= acc_d;
         if (io.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      ptag_q <= {ptag_q[PIPE_LAT-1:0], io.in_tag};
      if (push) begin
         res_mem[wr_ptr_q] <= push_result;
         flg_mem[wr_ptr_q] <= push_fflags;
         tag_mem[wr_ptr_q] <= push_tag;
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(push && (fifo_cnt_q == CNT_W'(OUT_DEPTH))));

   assign io.in_ready   = in_ready;
   assign io.dp_valid   = pv_q[0];
   assign io.dp_start   = dp_start_q;
   assign io.dp_kill    = dp_kill_q;
   assign io.dp_a       = dp_a_q;
   assign io.dp_b       = dp_b_q;
   assign io.dp_c       = dp_c_q;
   assign io.dp_ctrl    = dp_ctrl_q;
   assign io.dp_rm      = dp_rm_q;
   assign io.out_valid  = (fifo_cnt_q != '0);
   assign io.out_result = res_mem[rd_ptr_q];
   assign io.out_fflags = flg_mem[rd_ptr_q];
   assign io.out_tag    = tag_mem[rd_ptr_q];
   assign io.fflags_acc = acc_q;
   assign io.busy       = (occ != '0);

endmodule

// File: tb/tb_fp_execute_pipe.sv
// Directed bench for fp_execute_pipe; the bench datapath returns a^b with dp_ctrl as fflags.
module tb_fp_execute_pipe;
   localparam int unsigned PIPE_LAT = 3;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   fp_execute_pipe_if #(.XLEN(32), .TAG_W(5)) bus ();

   fp_execute_pipe #(.XLEN(32), .TAG_W(5), .PIPE_LAT(PIPE_LAT), .OUT_DEPTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .io (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] pr_q [1:PIPE_LAT];
   logic [4:0]  pf_q [1:PIPE_LAT];

   always @(posedge clk) begin
      pr_q[1] <= bus.dp_a ^ bus.dp_b;
      pf_q[1] <= bus.dp_ctrl;
      for (int k = 2; k <= PIPE_LAT; k++) begin
         pr_q[k] <= pr_q[k-1];
         pf_q[k] <= pf_q[k-1];
      end
   end
   assign bus.dp_pipe_result = pr_q[PIPE_LAT];
   assign bus.dp_pipe_fflags = pf_q[PIPE_LAT];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [4:0] tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] ctrl, input logic iter);
      bus.in_valid     = 1'b1;
      bus.in_tag       = tag;
      bus.in_fp_rs1    = a;
      bus.in_fp_rs2    = b;
      bus.in_fp_rs3    = '0;
      bus.in_int_rs1   = '0;
      bus.in_ctrl      = ctrl;
      bus.in_rm        = '0;
      bus.in_int_to_fp = 1'b0;
      bus.in_iter      = iter;
   endtask

   task automatic test_reset();
      tick();
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_outputs: out_valid %b busy %b dp_valid %b want 0", bus.out_valid, bus.busy, bus.dp_valid); end
      vectors++; if (bus.fflags_acc !== 5'b0 || bus.dp_a !== 32'h0) begin miscompares++; $display("FAIL reset_acc_dp: acc %b dp_a %h want 0", bus.fflags_acc, bus.dp_a); end
      rst = 1'b0;
      #1;
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_pipelined();
      bus.out_ready = 1'b0;
      set_op(5'd5, 32'h3F800000, 32'h40000000, 5'd0, 1'b0);
      #1;
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL pipe_in_ready: got %b want 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.dp_valid !== 1'b1 || bus.dp_a !== 32'h3F800000 || bus.dp_b !== 32'h40000000) begin miscompares++; $display("FAIL pipe_issue: dp_valid %b dp_a %h dp_b %h want 1 3f800000 40000000", bus.dp_valid, bus.dp_a, bus.dp_b); end
      tick();
      vectors++; if (bus.dp_valid !== 1'b0 || bus.dp_a !== 32'h0 || bus.dp_b !== 32'h0) begin miscompares++; $display("FAIL pipe_gating: dp_valid %b dp_a %h dp_b %h want 0", bus.dp_valid, bus.dp_a, bus.dp_b); end
      tick();
      tick();
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL pipe_early: out_valid %b at c+4 want 0", bus.out_valid); end
      tick();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h7F800000 || bus.out_tag !== 5'd5) begin miscompares++; $display("FAIL pipe_retire: out_valid %b result %h tag %0d want 1 7f800000 5", bus.out_valid, bus.out_result, bus.out_tag); end
      tick();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h7F800000 || bus.out_tag !== 5'd5) begin miscompares++; $display("FAIL pipe_hold: out_valid %b result %h tag %0d want 1 7f800000 5", bus.out_valid, bus.out_result, bus.out_tag); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL pipe_drained: out_valid %b busy %b want 0 0", bus.out_valid, bus.busy); end
   endtask

   task automatic test_int_to_fp();
      bus.out_ready = 1'b1;
      set_op(5'd1, 32'hDEADBEEF, 32'h00000010, 5'd0, 1'b0);
      bus.in_int_to_fp = 1'b1;
      bus.in_int_rs1   = 32'h00000007;
      bus.in_fp_rs3    = 32'h0000ABCD;
      bus.in_rm        = 3'b011;
      tick();
      bus.in_valid     = 1'b0;
      bus.in_int_to_fp = 1'b0;
      vectors++; if (bus.dp_a !== 32'h7 || bus.dp_c !== 32'h0000ABCD || bus.dp_rm !== 3'b011) begin miscompares++; $display("FAIL int_sel: dp_a %h dp_c %h dp_rm %b want 7 abcd 011", bus.dp_a, bus.dp_c, bus.dp_rm); end
      tick();
      vectors++; if (bus.dp_a !== 32'h0 || bus.dp_b !== 32'h0 || bus.dp_c !== 32'h0 || bus.dp_rm !== 3'b0) begin miscompares++; $display("FAIL int_idle_zero: dp_a %h dp_b %h dp_c %h rm %b want 0", bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_rm); end
      for (int i = 0; i < 20 && bus.busy; i++) begin
         if (bus.out_valid) begin
            vectors++; if (bus.out_result !== 32'h00000017) begin miscompares++; $display("FAIL int_result: got %h want 00000017", bus.out_result); end
         end
         tick();
      end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL int_drain_timeout: busy %b want 0", bus.busy); end
   endtask

   task automatic test_back_to_back();
      int n;
      int ret;
      n   = 0;
      ret = 0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         set_op(5'(n), 32'(n) * 32'h11, 32'h100, 5'd0, 1'b0);
         bus.in_valid = (n < 6);
         #1;
         if (bus.in_valid && bus.in_ready) n++;
         tick();
      end
      #1;
      vectors++; if (n !== 4 || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_credit: accepted %0d in_ready %b want 4 0", n, bus.in_ready); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 40 && ret < 6; i++) begin
         set_op(5'(n), 32'(n) * 32'h11, 32'h100, 5'd0, 1'b0);
         bus.in_valid = (n < 6);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            vectors++; if (bus.out_tag !== 5'(ret) || bus.out_result !== ((32'(ret) * 32'h11) ^ 32'h100)) begin miscompares++; $display("FAIL b2b_order: tag %0d result %h want %0d %h", bus.out_tag, bus.out_result, ret, (32'(ret) * 32'h11) ^ 32'h100); end
            ret++;
         end
         if (bus.in_valid && bus.in_ready) n++;
         tick();
      end
      bus.in_valid = 1'b0;
      vectors++; if (ret !== 6 || n !== 6) begin miscompares++; $display("FAIL b2b_complete: retired %0d accepted %0d want 6 6", ret, n); end
      for (int i = 0; i < 10 && bus.busy; i++) tick();
   endtask

   task automatic test_iter();
      int stall;
      int starts;
      stall  = 0;
      starts = 0;
      bus.out_ready = 1'b1;
      set_op(5'd7, 32'h0, 32'h0, 5'd0, 1'b0);
      tick();
      set_op(5'd9, 32'h40490FDB, 32'h3F800000, 5'h0C, 1'b1);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (bus.in_ready) break;
         stall++;
         @(posedge clk);
      end
      vectors++; if (stall !== 4) begin miscompares++; $display("FAIL iter_wait_drain: stalled %0d cycles want 4", stall); end
      tick();
      bus.in_valid = 1'b0;
      bus.in_iter  = 1'b0;
      if (bus.dp_start) starts++;
      vectors++; if (bus.dp_start !== 1'b1 || bus.dp_a !== 32'h40490FDB || bus.dp_ctrl !== 5'h0C) begin miscompares++; $display("FAIL iter_start: start %b dp_a %h ctrl %h want 1 40490fdb 0c", bus.dp_start, bus.dp_a, bus.dp_ctrl); end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.dp_start) starts++;
      end
      vectors++; if (bus.dp_a !== 32'h40490FDB || bus.busy !== 1'b1) begin miscompares++; $display("FAIL iter_hold: dp_a %h busy %b want 40490fdb 1", bus.dp_a, bus.busy); end
      bus.dp_iter_done   = 1'b1;
      bus.dp_iter_result = 32'h12345678;
      bus.dp_iter_fflags = 5'b01000;
      tick();
      bus.dp_iter_done = 1'b0;
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd9 || bus.out_result !== 32'h12345678 || bus.out_fflags !== 5'b01000) begin miscompares++; $display("FAIL iter_retire: valid %b tag %0d result %h flags %b want 1 9 12345678 01000", bus.out_valid, bus.out_tag, bus.out_result, bus.out_fflags); end
      vectors++; if (starts !== 1 || bus.dp_a !== 32'h0) begin miscompares++; $display("FAIL iter_single_start: starts %0d dp_a %h want 1 0", starts, bus.dp_a); end
      tick();
      vectors++; if (bus.fflags_acc !== 5'b01000 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL iter_acc: acc %b busy %b want 01000 0", bus.fflags_acc, bus.busy); end
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      set_op(5'd3, 32'h0, 32'h0, 5'd0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
      set_op(5'd4, 32'h11111111, 32'h22222222, 5'd0, 1'b1);
      #1;
      vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_setup: in_ready %b out_valid %b want 1 1", bus.in_ready, bus.out_valid); end
      tick();
      bus.in_valid = 1'b0;
      bus.in_iter  = 1'b0;
      tick();
      tick();
      bus.flush = 1'b1;
      #1;
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
      tick();
      bus.flush = 1'b0;
      vectors++; if (bus.dp_kill !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dp_a !== 32'h0) begin miscompares++; $display("FAIL flush_kill: kill %b out_valid %b busy %b dp_a %h want 1 0 0 0", bus.dp_kill, bus.out_valid, bus.busy, bus.dp_a); end
      tick();
      vectors++; if (bus.dp_kill !== 1'b0) begin miscompares++; $display("FAIL flush_kill_pulse: kill %b want 0", bus.dp_kill); end
      tick();
      bus.dp_iter_done   = 1'b1;
      bus.dp_iter_result = 32'hBADBAD00;
      bus.dp_iter_fflags = 5'b11111;
      tick();
      bus.dp_iter_done = 1'b0;
      tick();
      vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.fflags_acc !== 5'b01000) begin miscompares++; $display("FAIL flush_stale_done: out_valid %b busy %b acc %b want 0 0 01000", bus.out_valid, bus.busy, bus.fflags_acc); end
   endtask

   task automatic test_fflags_clr();
      bus.fflags_clr = 1'b1;
      tick();
      bus.fflags_clr = 1'b0;
      vectors++; if (bus.fflags_acc !== 5'b0) begin miscompares++; $display("FAIL clr_alone: acc %b want 00000", bus.fflags_acc); end
      bus.out_ready = 1'b1;
      set_op(5'd2, 32'h0, 32'h0, 5'b10000, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 20 && bus.busy; i++) tick();
      vectors++; if (bus.fflags_acc !== 5'b10000) begin miscompares++; $display("FAIL clr_accumulate: acc %b want 10000", bus.fflags_acc); end
      bus.out_ready = 1'b0;
      set_op(5'd3, 32'h0, 32'h0, 5'b00001, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_fflags !== 5'b00001) begin miscompares++; $display("FAIL clr_retire_wait: out_valid %b flags %b want 1 00001", bus.out_valid, bus.out_fflags); end
      bus.out_ready  = 1'b1;
      bus.fflags_clr = 1'b1;
      tick();
      bus.out_ready  = 1'b0;
      bus.fflags_clr = 1'b0;
      vectors++; if (bus.fflags_acc !== 5'b00001 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_with_retire: acc %b out_valid %b want 00001 0", bus.fflags_acc, bus.out_valid); end
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      set_op(5'd6, 32'h5, 32'h3, 5'd0, 1'b0);
      tick();
      set_op(5'd7, 32'h1, 32'h2, 5'd0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
      vectors++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL areset_setup: out_valid %b busy %b want 1 1", bus.out_valid, bus.busy); end
      #2;
      rst = 1'b1;
      #1;
      vectors++; if (bus.out_valid !== 1'b0 || bus.fflags_acc !== 5'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL areset_async: out_valid %b acc %b busy %b want 0 00000 0", bus.out_valid, bus.fflags_acc, bus.busy); end
      vectors++; if (bus.in_ready !== 1'b0 || bus.dp_valid !== 1'b0 || bus.dp_a !== 32'h0) begin miscompares++; $display("FAIL areset_dp: in_ready %b dp_valid %b dp_a %h want 0 0 0", bus.in_ready, bus.dp_valid, bus.dp_a); end
      #2;
      rst = 1'b0;
      tick();
      vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_release: in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid); end
   endtask

   initial begin
      vectors            = 0;
      miscompares        = 0;
      rst                = 1'b1;
      bus.in_valid       = 1'b0;
      bus.in_tag         = '0;
      bus.in_fp_rs1      = '0;
      bus.in_fp_rs2      = '0;
      bus.in_fp_rs3      = '0;
      bus.in_int_rs1     = '0;
      bus.in_ctrl        = '0;
      bus.in_rm          = '0;
      bus.in_int_to_fp   = 1'b0;
      bus.in_iter        = 1'b0;
      bus.dp_iter_done   = 1'b0;
      bus.dp_iter_result = '0;
      bus.dp_iter_fflags = '0;
      bus.out_ready      = 1'b0;
      bus.flush          = 1'b0;
      bus.fflags_clr     = 1'b0;
      test_reset();
      test_pipelined();
      test_int_to_fp();
      test_back_to_back();
      test_iter();
      test_flush();
      test_fflags_clr();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fp_execute_pipe.md
# fp_execute_pipe

Parametrised, handshaked floating-point execute stage that replaces the gated combinational FP execute wrapper. It selects and registers operands (integer or FP source), issues them to an external FP datapath in one of two classes: fixed-latency pipelined (add/mul/fma/cvt) or variable-latency iterative (div/sqrt). It retires results strictly in order through an output FIFO with valid/ready, tags and sticky fflags accumulation. It sits between the FP issue/forwarding logic and FP writeback.

## Interface
- XLEN, 32, operand/result width
- TAG_W, 5, width of the writeback tag carried with each op
- PIPE_LAT, 3, datapath latency of pipelined ops in cycles (>=1)
- OUT_DEPTH, 4, output FIFO depth, power of two, >=2

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid / in_ready  in / out  1  issue handshake
- in_tag  in  TAG_W  op tag
- in_fp_rs1, in_fp_rs2, in_fp_rs3, in_int_rs1  in  XLEN  forwarded operands
- in_ctrl  in  5  fp_alu_control encoding; in_rm  in  3  rounding mode
- in_int_to_fp  in  1  operand A from in_int_rs1; in_iter  in  1  iterative class
- dp_valid  out  1  pipelined issue strobe; dp_start  out  1  iterative start pulse; dp_kill  out  1  abort iterative op
- dp_a, dp_b, dp_c  out  XLEN; dp_ctrl  out  5; dp_rm  out  3  registered datapath inputs
- dp_pipe_result  in  XLEN; dp_pipe_fflags  in  5  pipelined result, valid PIPE_LAT cycles after dp_valid
- dp_iter_done  in  1; dp_iter_result  in  XLEN; dp_iter_fflags  in  5  iterative completion
- out_valid / out_ready  out / in  1  retire handshake
- out_result  out  XLEN; out_fflags  out  5; out_tag  out  TAG_W  FIFO head
- flush  in  1  synchronous pipeline flush
- fflags_clr  in  1  clear accumulator; fflags_acc  out  5  sticky OR of retired fflags
- busy  out  1  any op in flight or FIFO non-empty

## Operation
- Operand select: A = in_int_to_fp ? in_int_rs1 : in_fp_rs1; B = rs2; C = rs3. Registered into dp_a/b/c/ctrl/rm on accept.
- Power gating: dp_a/b/c/ctrl/rm are zero in every cycle without dp_valid and outside an active iterative op.
- Pipelined class: valid+tag shift register of PIPE_LAT+1 stages. dp_pipe_result/fflags are captured into the FIFO when the stage aligned with cycle t+PIPE_LAT is valid.
- Iterative FSM: IDLE -> ITER on an accepted in_iter op (dp_start pulses one cycle, operands held). ITER -> IDLE on dp_iter_done (result, fflags and tag are pushed) or on flush (dp_kill pulses one cycle). dp_iter_done in IDLE is ignored.
- Credits: occ = FIFO count + in-flight ops. A same-cycle pop frees a credit immediately.
- in_ready = !rst && !flush && state==IDLE && occ<OUT_DEPTH && (!in_iter || pipeline empty).
- Ordering: strictly in issue order; an iterative op never overlaps pipelined ops.
- fflags_acc |= out_fflags on each out_valid&&out_ready. If fflags_clr coincides with a retire, the result is that retire's flags only.
- flush: clears FIFO, shift register and FSM in one edge. fflags_acc is unaffected.

## Timing
- Reset (async): FIFO empty, FSM IDLE, all shift valids 0, out_valid=0, dp_valid=dp_start=dp_kill=0, dp_* buses=0, fflags_acc=0, busy=0. in_ready=0 while rst is high and 1 in the first cycle after release.
- Pipelined latency: accept in cycle c -> dp_valid in c+1 -> out_valid in c+2+PIPE_LAT (c+5 at default). Throughput is one op per cycle.
- Iterative: accept in c -> dp_start in c+1. dp_iter_done in cycle d -> out_valid in d+1.
- out_* hold stable while out_valid && !out_ready.
- A FIFO push and pop in the same cycle leaves the count unchanged. Full+push never occurs by construction; assert it.
- Reset asserted mid-operation zeroes outputs asynchronously, with no partial retire.

## Test plan
- Pipelined op with tag 5, in_fp_rs1=0x3F800000, in_fp_rs2=0x40000000; bench datapath returns a^b -> dp_valid in c+1 with dp_a=0x3F800000; out_valid in c+5 with out_result=0x7F800000, out_tag=5.
- in_int_to_fp=1, in_int_rs1=0x00000007 -> dp_a=0x00000007. In idle cycles dp_a=dp_b=dp_c=0.
- Six back-to-back ops (tags 0..5) with out_ready=0 -> exactly 4 accepted and in_ready low. Raise out_ready -> retire order 0,1,2,3, then 4,5 accepted and retired in order.
- in_iter op presented while a pipelined op is in flight -> in_ready=0 until the pipeline drains, then accepted. dp_start pulses exactly once. dp_iter_done 10 cycles later with fflags 5'b01000 -> out_valid next cycle, fflags_acc=5'b01000.
- flush during ITER -> dp_kill for 1 cycle, FIFO empty, busy=0. A dp_iter_done arriving 3 cycles later is ignored. fflags_acc is unchanged.
- fflags_clr coincident with a retire carrying 5'b00001 (acc was 5'b10000) -> fflags_acc=5'b00001. Async rst mid-stream -> out_valid=0 and fflags_acc=0 before the next clk edge.
